// File: rtl/fpmult_rr_arbiter_if.sv
// fpmult_rr_arbiter_if: requester, response and FPMult-side signals of the shared multiplier arbiter
interface fpmult_rr_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]   req_valid;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [3*N_REQ-1:0] req_ctrl;
    logic [N_REQ-1:0]   req_ready;
    logic               drain;
    logic               idle;
    logic [31:0]        mult_a;
    logic [31:0]        mult_b;
    logic [2:0]         mult_ctrl;
    logic [31:0]        mult_p;
    logic [N_REQ-1:0]   rsp_valid;
    logic [31:0]        rsp_p;
    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, drain, mult_p,
        output req_ready, idle, mult_a, mult_b, mult_ctrl, rsp_valid, rsp_p
    );
    modport master (
        output req_valid, req_a, req_b, req_ctrl, drain, mult_p,
        input  req_ready, idle, mult_a, mult_b, mult_ctrl, rsp_valid, rsp_p
    );
endinterface

// File: rtl/fpmult_rr_arbiter.sv
// fpmult_rr_arbiter: round-robin sharing of one FPMult among N_REQ requesters; FPMULT_RR_ARBITER_PRIO0_EN gives port 0 strict priority
module fpmult_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MULT_LAT = 0,
    parameter int TAG_W    = 2
) (
    input logic clk,
    input logic rst_n,
    fpmult_rr_arbiter_if.slave bus
);
    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] gidx;
    logic [TAG_W-1:0] k;
    logic             found;
    logic             accept;
    logic             hold_ptr;
    logic             any_v;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic [2:0]       sel_c;
    logic             stage_v [MULT_LAT+1];
    logic [TAG_W-1:0] stage_t [MULT_LAT+1];

    // first valid port at or after rr_ptr, optionally overridden by port 0
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = TAG_W'((int'(rr_ptr) + i) % N_REQ);
            if (!found && bus.req_valid[k]) begin
                found = 1'b1;
                gidx  = k;
            end
        end
`ifdef FPMULT_RR_ARBITER_PRIO0_EN
        if (bus.req_valid[0]) begin
            found = 1'b1;
            gidx  = '0;
        end
`endif
    end

`ifdef FPMULT_RR_ARBITER_PRIO0_EN
    assign hold_ptr = bus.req_valid[0];
`else
    assign hold_ptr = 1'b0;
`endif

    assign accept        = found & ~bus.drain;
    assign bus.req_ready = accept ? (N_REQ'(1) << gidx) : '0;
    assign bus.idle      = ~|bus.req_ready & ~any_v & ~|bus.rsp_valid;

    // operand mux for the granted port
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gidx == TAG_W'(i)) begin
                sel_a = bus.req_a[32*i +: 32];
                sel_b = bus.req_b[32*i +: 32];
                sel_c = bus.req_ctrl[3*i +: 3];
            end
        end
    end

    // any operation still travelling through the tag pipeline
    always_comb begin
        any_v = 1'b0;
        for (int i = 0; i <= MULT_LAT; i++) any_v = any_v | stage_v[i];
    end

    // register granted operands into the multiplier and advance the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mult_a    <= '0;
            bus.mult_b    <= '0;
            bus.mult_ctrl <= '0;
            rr_ptr        <= '0;
        end else if (accept) begin
            bus.mult_a    <= sel_a;
            bus.mult_b    <= sel_b;
            bus.mult_ctrl <= sel_c;
            if (!hold_ptr) rr_ptr <= (gidx == TAG_W'(N_REQ-1)) ? '0 : gidx + 1'b1;
        end
    end

    // tag pipeline matching the multiplier latency, never stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= MULT_LAT; i++) begin
                stage_v[i] <= 1'b0;
                stage_t[i] <= '0;
            end
        end else begin
            stage_v[0] <= accept;
            stage_t[0] <= gidx;
            for (int i = 1; i <= MULT_LAT; i++) begin
                stage_v[i] <= stage_v[i-1];
                stage_t[i] <= stage_t[i-1];
            end
        end
    end

    // capture the product and strobe the originating port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= '0;
            bus.rsp_p     <= '0;
        end else begin
            bus.rsp_valid <= stage_v[MULT_LAT] ? (N_REQ'(1) << stage_t[MULT_LAT]) : '0;
            if (stage_v[MULT_LAT]) bus.rsp_p <= bus.mult_p;
        end
    end
endmodule

// File: tb/tb_fpmult_rr_arbiter.sv
// tb_fpmult_rr_arbiter: directed checks of grant order, latency, drain/idle and reset for the shared FPMult arbiter
module tb_fpmult_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    logic [31:0] p1, p2, p3;
    logic [31:0] ta [4] = '{32'h3F800000, 32'h40400000, 32'h40400000, 32'h40200000};
    logic [31:0] tb_ [4] = '{32'h3F800000, 32'h40000000, 32'hC0000000, 32'h40980000};
    logic [31:0] tp [4] = '{32'h3F800000, 32'h40C00000, 32'hC0C00000, 32'h413E0000};

    always #5 clk = ~clk;

    fpmult_rr_arbiter_if #(.N_REQ(4)) b();
    fpmult_rr_arbiter_if #(.N_REQ(4)) b3();

    fpmult_rr_arbiter #(.N_REQ(4), .MULT_LAT(0), .TAG_W(2)) u (.clk(clk), .rst_n(rst_n), .bus(b));
    fpmult_rr_arbiter #(.N_REQ(4), .MULT_LAT(3), .TAG_W(2)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    // hand-computed single-precision products for the operand pairs used here
    function automatic logic [31:0] lut(input logic [31:0] a, input logic [31:0] bb);
        case ({a, bb})
            64'h40200000_40980000: lut = 32'h413E0000;
            64'h3F800000_3F800000: lut = 32'h3F800000;
            64'h40400000_40000000: lut = 32'h40C00000;
            64'h40400000_C0000000: lut = 32'hC0C00000;
            default:               lut = 32'h7FC00000;
        endcase
    endfunction

    assign b.mult_p = lut(b.mult_a, b.mult_b);

    // three-cycle pipelined multiplier model for the MULT_LAT=3 instance
    always @(posedge clk) begin
        p1 <= lut(b3.mult_a, b3.mult_b);
        p2 <= p1;
        p3 <= p2;
    end
    assign b3.mult_p = p3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int p, input logic [31:0] a, input logic [31:0] bb, input logic [2:0] c, input logic v);
        b.req_a[32*p +: 32] = a;
        b.req_b[32*p +: 32] = bb;
        b.req_ctrl[3*p +: 3] = c;
        b.req_valid[p] = v;
    endtask

    initial begin
        rst_n = 1'b0;
        b.req_valid = '0; b.req_a = '0; b.req_b = '0; b.req_ctrl = '0; b.drain = 1'b0;
        b3.req_valid = '0; b3.req_a = '0; b3.req_b = '0; b3.req_ctrl = '0; b3.drain = 1'b0;
        #3;
        chk("rst_idle", 32'(b.idle), 32'd1);
        chk("rst_rsp_valid", 32'(b.rsp_valid), 32'd0);
        chk("rst_rsp_p", b.rsp_p, 32'd0);
        chk("rst_mult_a", b.mult_a, 32'd0);
        chk("rst_mult_ctrl", 32'(b.mult_ctrl), 32'd0);
        chk("rst_idle_l3", 32'(b3.idle), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        tick;

        // latency 3: back-to-back issues from port 1
        b3.req_valid = 4'b0010; b3.req_a[63:32] = ta[0]; b3.req_b[63:32] = tb_[0];
        #1 chk("l3_ready", 32'(b3.req_ready), 32'h2);
        tick;
        b3.req_a[63:32] = ta[1]; b3.req_b[63:32] = tb_[1];
        tick;
        b3.req_a[63:32] = ta[2]; b3.req_b[63:32] = tb_[2];
        tick;
        b3.req_valid = '0;
        tick;
        chk("l3_no_early", 32'(b3.rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("l3_rsp_valid", 32'(b3.rsp_valid), 32'h2);
            chk("l3_rsp_p", b3.rsp_p, tp[i]);
        end
        tick;
        chk("l3_rsp_end", 32'(b3.rsp_valid), 32'd0);
        chk("l3_idle", 32'(b3.idle), 32'd1);

        // single op from port 2
        put(2, 32'h40200000, 32'h40980000, 3'd0, 1'b1);
        #1 chk("t1_ready", 32'(b.req_ready), 32'h4);
        chk("t1_busy", 32'(b.idle), 32'd0);
        tick;
        b.req_valid = '0;
        chk("t1_mult_a", b.mult_a, 32'h40200000);
        chk("t1_mult_b", b.mult_b, 32'h40980000);
        chk("t1_idle_inflight", 32'(b.idle), 32'd0);
        tick;
        chk("t1_rsp_valid", 32'(b.rsp_valid), 32'h4);
        chk("t1_rsp_p", b.rsp_p, 32'h413E0000);
        tick;
        chk("t1_rsp_clear", 32'(b.rsp_valid), 32'd0);
        chk("t1_rsp_hold", b.rsp_p, 32'h413E0000);
        chk("t1_idle", 32'(b.idle), 32'd1);

        // drain with two ops in flight and port 3 waiting
        put(3, 32'h40200000, 32'h40980000, 3'd5, 1'b1);
        put(0, 32'h3F800000, 32'h3F800000, 3'd0, 1'b1);
        #1 chk("t4_ready_p3", 32'(b.req_ready), 32'h8);
        tick;
        chk("t4_mult_ctrl", 32'(b.mult_ctrl), 32'd5);
        chk("t4_ready_p0", 32'(b.req_ready), 32'h1);
        tick;
        b.drain = 1'b1;
        b.req_valid[0] = 1'b0;
        #1 chk("t4_drain_ready", 32'(b.req_ready), 32'd0);
        chk("t4_rsp1_valid", 32'(b.rsp_valid), 32'h8);
        chk("t4_rsp1_p", b.rsp_p, 32'h413E0000);
        tick;
        chk("t4_rsp2_valid", 32'(b.rsp_valid), 32'h1);
        chk("t4_rsp2_p", b.rsp_p, 32'h3F800000);
        chk("t4_drain_ready2", 32'(b.req_ready), 32'd0);
        chk("t4_busy", 32'(b.idle), 32'd0);
        tick;
        chk("t4_idle", 32'(b.idle), 32'd1);
        chk("t4_drain_ready3", 32'(b.req_ready), 32'd0);
        tick;
        chk("t4_idle_hold", 32'(b.idle), 32'd1);
        b.drain = 1'b0;
        #1 chk("t4_release_ready", 32'(b.req_ready), 32'h8);
        tick;
        b.req_valid = '0;
        tick;
        chk("t4_p3_rsp", 32'(b.rsp_valid), 32'h8);
        tick;
        chk("t4_idle_end", 32'(b.idle), 32'd1);

        // all four ports at once
        for (int i = 0; i < 4; i++) put(i, ta[i], tb_[i], 3'd0, 1'b1);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant", 32'(b.req_ready), 32'(1) << i);
            tick;
            if (i > 0) begin
                chk("t2_rsp_valid", 32'(b.rsp_valid), 32'(1) << (i - 1));
                chk("t2_rsp_p", b.rsp_p, tp[i-1]);
            end
        end
        b.req_valid = '0;
        tick;
        chk("t2_rsp_valid", 32'(b.rsp_valid), 32'h8);
        chk("t2_rsp_p", b.rsp_p, tp[3]);

        // ports 0 and 1 both continuously valid
        b.req_valid = 4'b0011;
        #1;
        for (int i = 0; i < 4; i++) begin
`ifdef FPMULT_RR_ARBITER_PRIO0_EN
            chk("t6_grant", 32'(b.req_ready), 32'h1);
`else
            chk("t6_grant", 32'(b.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
`endif
            tick;
        end
        b.req_valid = '0;
        tick;
        tick;
        chk("t6_idle", 32'(b.idle), 32'd1);

        // reset with two ops in flight
        b.req_valid = 4'b1100;
        tick;
        tick;
        b.req_valid = '0;
        #1 rst_n = 1'b0;
        #1 chk("t5_rsp_valid", 32'(b.rsp_valid), 32'd0);
        chk("t5_mult_a", b.mult_a, 32'd0);
        chk("t5_idle", 32'(b.idle), 32'd1);
        tick;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t5_no_rsp", 32'(b.rsp_valid), 32'd0);
        end
        b.req_valid = 4'b1010;
        #1 chk("t5_lowest_grant", 32'(b.req_ready), 32'h2);
        tick;
        b.req_valid = '0;
        tick;
        chk("t5_rsp_valid", 32'(b.rsp_valid), 32'h2);
        chk("t5_rsp_p", b.rsp_p, 32'h40C00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpmult_rr_arbiter.md
Name: fpmult_rr_arbiter

Overview:
- Shares one single-precision FPMult datapath (A, B, Ctrl[2:0] in; P[31:0] out) among N_REQ requesters.
- Arbitrates round-robin, one issue per cycle, and registers operands into the multiplier.
- Tracks the requester tag through the multiplier's fixed latency and returns each product, registered, to the originating port.
- Sits between the DSP-side operand producers and the FPMult instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MULT_LAT, 0, FPMult pipeline depth in cycles (0 = combinational FPMult).
- TAG_W, 2, tag width; must satisfy 2**TAG_W >= N_REQ.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-port operand valid.
- req_a  in  32*N_REQ  port i operand A in bits [32i+31:32i].
- req_b  in  32*N_REQ  port i operand B, same packing.
- req_ctrl  in  3*N_REQ  port i Ctrl, bits [3i+2:3i].
- req_ready  out  N_REQ  one-hot grant; a transfer happens on valid&ready.
- drain  in  1  when high, no new grants are issued.
- idle  out  1  high when no operation is in flight and none is being accepted.
- mult_a  out  32  registered operand A to FPMult.
- mult_b  out  32  registered operand B to FPMult.
- mult_ctrl  out  3  registered Ctrl to FPMult.
- mult_p  in  32  FPMult product.
- rsp_valid  out  N_REQ  one-hot, single-cycle result strobe.
- rsp_p  out  32  registered product; meaningful only while rsp_valid is nonzero.

Behaviour:
- Reset (asynchronous): rsp_valid=0, rsp_p=0, mult_a/b/ctrl=0, rr_ptr=0, tag pipeline cleared, idle=1.
- req_ready is combinational:
  - With drain=0, exactly the first port with req_valid set, searching from rr_ptr upward with wrap at N_REQ-1 -> 0, gets ready=1.
  - With drain=1 or no valid request, req_ready=0.
  - req_ready depends on req_valid in the same cycle.
- On an accept edge (port g granted):
  - mult_a/b/ctrl load port g's operands.
  - Tag pipeline stage 0 loads {1, g}.
  - rr_ptr <= (g+1) mod N_REQ.
- With no accept: mult_* hold their values, stage 0 loads valid=0, rr_ptr holds.
- Tag pipeline depth is MULT_LAT+1 and shifts every cycle; there is no stall.
- When the final stage is valid:
  - rsp_p <= mult_p and rsp_valid <= onehot(tag) on the next edge.
  - Otherwise rsp_valid <= 0 and rsp_p holds.
- Latency: rsp_valid asserts exactly MULT_LAT+1 cycles after the accept edge. Throughput is 1 result per cycle.
- Ordering: results return in issue order; back-to-back issues from the same port return on consecutive cycles.
- There is no response backpressure; requesters must sink every rsp_valid.
- idle = ~|req_ready & no valid stage in the tag pipeline & rsp_valid==0.
- Simultaneous drain rising and a pending request: drain wins that cycle; no accept.
- In-flight operations complete normally under drain.
- A request withdrawn before it is accepted is legal; rr_ptr is unaffected.
- Reset mid-operation drops in-flight operations; no rsp_valid follows reset deassertion until a new accept.
- Fairness: with all ports valid, grants cycle 0,1,...,N_REQ-1,0.

Optional Feature:
- Macro: FPMULT_RR_ARBITER_PRIO0_EN.
- Defined: port 0 has strict priority. Whenever req_valid[0]=1 and drain=0, port 0 is granted and rr_ptr is not updated. The other ports are round-robin among themselves when port 0 is not requesting.
- Undefined: pure round-robin over all ports as above.

Test Plan:
1. Single op, MULT_LAT=0:
   - Stimulus: port 2 presents A=0x40200000, B=0x40980000, Ctrl=0.
   - Response: accepted in 1 cycle; next cycle rsp_valid=4'b0100, rsp_p=0x413E0000.
2. All four ports valid simultaneously:
   - Stimulus: port 0 1.0*1.0 (0x3F800000 both), port 1 0x40400000*0x40000000, port 2 0x40400000*0xC0000000, port 3 2.5*4.75.
   - Response: grants in order 0,1,2,3 on consecutive cycles; results 0x3F800000, 0x40C00000, 0xC0C00000, 0x413E0000 on rsp_valid 0001, 0010, 0100, 1000.
3. MULT_LAT=3 build, with a latency-matched FPMult model:
   - Stimulus: back-to-back issues from port 1.
   - Response: each rsp_valid arrives exactly 4 cycles after its accept; results arrive in order with no gaps.
4. Drain and idle:
   - Stimulus: drain=1 with 2 ops in flight and port 3 valid.
   - Response: req_ready stays 0; both results are delivered; idle=1 after the last rsp_valid; the port 3 grant follows drain=0.
5. Reset mid-flight:
   - Stimulus: rst_n low 1 cycle while 2 ops are in flight.
   - Response: rsp_valid stays 0 afterwards, rr_ptr=0, and the first grant goes to the lowest valid port.
6. FPMULT_RR_ARBITER_PRIO0_EN defined:
   - Stimulus: ports 0 and 1 continuously valid.
   - Response: port 1 is never granted while port 0 is valid. With the macro undefined, grants alternate 0,1,0,1.
